// File: rtl/axis_fir_mac_mc.sv
// Multi-channel AXI-Stream FIR filter with one shared, time-multiplexed MAC.
// Each channel owns a NUM_TAPS-deep circular delay line stored in a single RAM
// addressed as {channel, tap index}. Coefficients are runtime-writable
// fixed-point values shared by all channels. Results are rounded and saturated.
// Optional feature macro: FIR_BYPASS_EN adds a 'bypass' input that skips the
// MAC and forwards the raw sample while still updating the delay line.
module axis_fir_mac_mc #(
  parameter int DATA_WIDTH   = 24,
  parameter int COEF_WIDTH   = 18,
  parameter int COEF_FRAC    = 16,
  parameter int NUM_TAPS     = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int ACC_WIDTH    = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                        axis_clk,
  input  logic                        axis_resetn,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
`ifdef FIR_BYPASS_EN
  input  logic                        bypass,
`endif
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic                        coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_WIDTH-1:0]       coef_wr_data,
  output logic                        coef_wr_ready
);

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MEM_W  = CH_W + TAP_W;
  localparam int DEPTH  = NUM_CHANNELS * NUM_TAPS;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int RND_W  = ACC_WIDTH + 1;

  localparam logic [MEM_W-1:0] CLR_LAST = MEM_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(64'sd1 <<< COEF_FRAC);
  localparam logic signed [RND_W-1:0] HALF_LSB = RND_W'(64'sd1 <<< (COEF_FRAC - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT
  } state_t;

  state_t                       state_q, state_d;
  logic [MEM_W-1:0]             clr_q;
  logic [TAP_W-1:0]             tap_q;
  logic [CH_W-1:0]              ch_q;
  logic [TAP_W-1:0]             wp_q [NUM_CHANNELS];
  logic                         last_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] dline_q [DEPTH];
  logic [DATA_WIDTH-1:0]        tdata_q;

  logic                         in_fire;
  logic                         out_fire;
  logic                         coef_fire;
  logic                         take_bypass;
  logic [TAP_W-1:0]             rd_idx;
  logic signed [DATA_WIDTH-1:0] x_rd;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [RND_W-1:0]      rnd;
  logic signed [RND_W-1:0]      shr;
  logic [DATA_WIDTH-1:0]        sat_y;

`ifdef FIR_BYPASS_EN
  logic                         bypass_q;
  logic [DATA_WIDTH-1:0]        sample_q;
  assign take_bypass = bypass;
`else
  assign take_bypass = 1'b0;
`endif

  assign in_fire   = s_axis_tvalid & s_axis_tready;
  assign out_fire  = m_axis_tvalid & m_axis_tready;
  assign coef_fire = coef_wr_en & coef_wr_ready;

  // Tap k of the current channel reads the sample written k beats ago.
  assign rd_idx   = wp_q[ch_q] - tap_q;
  assign x_rd     = dline_q[{ch_q, rd_idx}];
  assign prod     = coef_q[tap_q] * x_rd;
  assign prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};

  assign m_axis_tdata = tdata_q;
  assign m_axis_tlast = last_q;

  // Round half-up at the coefficient binary point, then clamp to the sample range.
  always_comb begin
    rnd   = $signed({acc_q[ACC_WIDTH-1], acc_q}) + HALF_LSB;
    shr   = rnd >>> COEF_FRAC;
    sat_y = shr[DATA_WIDTH-1:0];
    if (shr > SAT_MAX) begin
      sat_y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shr < SAT_MIN) begin
      sat_y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // State register; reset always restarts with a full delay-line clear.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear, wait for a beat, run all taps, round, hand off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_q == CLR_LAST) state_d = ST_IDLE;
      ST_IDLE:  if (in_fire) state_d = take_bypass ? ST_ROUND : ST_MAC;
      ST_MAC:   if (tap_q == TAP_LAST) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_OUT;
      ST_OUT:   if (m_axis_tready) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    s_axis_tready = 1'b0;
    coef_wr_ready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_axis_tready = 1'b1;
        coef_wr_ready = 1'b1;
      end
      ST_OUT:  m_axis_tvalid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: clear counter, coefficients, accumulator, pointers, result.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      clr_q   <= '0;
      tap_q   <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      tdata_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) wp_q[i] <= '0;
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= (i == 0) ? COEF_ONE : '0;
`ifdef FIR_BYPASS_EN
      bypass_q <= 1'b0;
      sample_q <= '0;
`endif
    end else begin
      if (coef_fire) begin
        coef_q[coef_wr_addr] <= coef_wr_data;
      end
      case (state_q)
        ST_CLEAR: clr_q <= clr_q + 1'b1;
        ST_IDLE: begin
          if (in_fire) begin
            last_q <= s_axis_tlast;
            acc_q  <= '0;
            tap_q  <= '0;
`ifdef FIR_BYPASS_EN
            bypass_q <= bypass;
            sample_q <= s_axis_tdata;
`endif
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + prod_ext;
          tap_q <= tap_q + 1'b1;
        end
        ST_ROUND: begin
`ifdef FIR_BYPASS_EN
          tdata_q <= bypass_q ? sample_q : sat_y;
`else
          tdata_q <= sat_y;
`endif
        end
        ST_OUT: begin
          if (out_fire) begin
            wp_q[ch_q] <= wp_q[ch_q] + 1'b1;
            ch_q       <= (last_q || ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Delay-line RAM: zeroed word by word in CLEAR, written by each accepted beat.
  always_ff @(posedge axis_clk) begin
    if (state_q == ST_CLEAR) begin
      dline_q[clr_q] <= '0;
    end else if (in_fire) begin
      dline_q[{ch_q, wp_q[ch_q]}] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_axis_fir_mac_mc.sv
// Scoreboard bench for axis_fir_mac_mc: the driver pushes hand-computed
// expected results, an independent monitor pops and compares output beats.
module tb_axis_fir_mac_mc;

  localparam int DW  = 24;
  localparam int CW  = 18;
  localparam int NT  = 32;
  localparam int NC  = 2;
  localparam int LAT = NT + 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic                  axis_clk = 1'b0;
  logic                  axis_resetn = 1'b0;
  logic [DW-1:0]         s_axis_tdata = '0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic                  s_axis_tlast = 1'b0;
  logic [DW-1:0]         m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b1;
  logic                  m_axis_tlast;
  logic                  coef_wr_en = 1'b0;
  logic [$clog2(NT)-1:0] coef_wr_addr = '0;
  logic [CW-1:0]         coef_wr_data = '0;
  logic                  coef_wr_ready;

  exp_t expQ[$];
  int   accQ[$];
  int   assertions = 0;
  int   failures = 0;
  int   outBeats = 0;
  int   cyc = 0;
  logic prevValid = 1'b0;

  axis_fir_mac_mc #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(16), .NUM_TAPS(NT), .NUM_CHANNELS(NC)
  ) dut (
    .axis_clk(axis_clk),
    .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
`ifdef FIR_BYPASS_EN
    .bypass(1'b0),
`endif
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .coef_wr_ready(coef_wr_ready)
  );

  // 100 MHz clock.
  always #5 axis_clk = ~axis_clk;

  // Cycle counter used for latency measurement.
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: latency on each rising tvalid, data/tlast on each output handshake.
  always @(negedge axis_clk) begin
    exp_t e;
    int   c;
    if (!axis_resetn) begin
      prevValid = 1'b0;
    end else begin
      if (m_axis_tvalid && !prevValid) begin
        if (accQ.size() == 0) begin
          checkOutput("latency_no_accept", 32'd1, 32'd0);
        end else begin
          c = accQ.pop_front();
          checkOutput("latency", cyc - c, LAT);
        end
      end
      prevValid = m_axis_tvalid;
      if (m_axis_tvalid && m_axis_tready) begin
        outBeats++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", m_axis_tdata, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("tdata", m_axis_tdata, e.data);
          checkOutput("tlast", m_axis_tlast, e.last);
        end
      end
      if (s_axis_tvalid && s_axis_tready) accQ.push_back(cyc);
    end
  end

  task automatic doReset();
    int zeros;
    @(posedge axis_clk);
    #2 axis_resetn = 1'b0;
    #1;
    checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_s_tready", s_axis_tready, 0);
    checkOutput("rst_coef_ready", coef_wr_ready, 0);
    checkOutput("rst_m_tdata", m_axis_tdata, 0);
    checkOutput("rst_m_tlast", m_axis_tlast, 0);
    repeat (3) @(posedge axis_clk);
    accQ.delete();
    #1 axis_resetn = 1'b1;
    zeros = 0;
    repeat (NT * NC) begin
      @(negedge axis_clk);
      if (!s_axis_tready) zeros++;
    end
    checkOutput("clear_len", zeros, NT * NC);
    @(negedge axis_clk);
    checkOutput("tready_after_clear", s_axis_tready, 1);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input logic last,
                               input logic [DW-1:0] expData, input logic expLast, input bit track);
    exp_t e;
    bit   got;
    if (track) begin
      e.data = expData;
      e.last = expLast;
      expQ.push_back(e);
    end
    @(posedge axis_clk);
    #1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge axis_clk);
      if (s_axis_tready) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("accept_wait", got, 1);
    @(posedge axis_clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic writeCoef(input int addr, input logic [CW-1:0] data);
    bit got;
    @(posedge axis_clk);
    #1;
    coef_wr_addr = addr[$clog2(NT)-1:0];
    coef_wr_data = data;
    coef_wr_en   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge axis_clk);
      if (coef_wr_ready) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("coef_wait", got, 1);
    @(posedge axis_clk);
    #1 coef_wr_en = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge axis_clk);
      if (expQ.size() == 0) break;
    end
    repeat (2) @(negedge axis_clk);
    checkOutput("drain", expQ.size(), 0);
  endtask

  // Hard stop in case the DUT stalls somewhere no bounded wait covers.
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    logic [DW-1:0] expL [5];
    int beatsBefore;
    bit seen;

    // Identity filter after reset, tlast passthrough.
    doReset();
    applyStimulus(24'h100000, 1'b0, 24'h100000, 1'b0, 1'b1);
    applyStimulus(24'hF00000, 1'b1, 24'hF00000, 1'b1, 1'b1);
    waitDrain();

    // Decaying impulse response on L, R stays silent.
    doReset();
    writeCoef(0, 18'h08000);
    writeCoef(1, 18'h04000);
    writeCoef(2, 18'h02000);
    writeCoef(3, 18'h01000);
    expL[0] = 24'h080000;
    expL[1] = 24'h040000;
    expL[2] = 24'h020000;
    expL[3] = 24'h010000;
    expL[4] = 24'h000000;
    for (int f = 0; f < 5; f++) begin
      applyStimulus((f == 0) ? 24'h100000 : 24'h000000, 1'b0, expL[f], 1'b0, 1'b1);
      applyStimulus(24'h000000, 1'b1, 24'h000000, 1'b1, 1'b1);
    end
    waitDrain();

    // Saturation at both rails, then round-half-up for +/- 2.25.
    doReset();
    writeCoef(0, 18'h1FFFF);
    applyStimulus(24'h7FFFFF, 1'b0, 24'h7FFFFF, 1'b0, 1'b1);
    applyStimulus(24'h800000, 1'b1, 24'h800000, 1'b1, 1'b1);
    waitDrain();
    writeCoef(0, 18'h0C000);
    applyStimulus(24'h000003, 1'b0, 24'h000002, 1'b0, 1'b1);
    applyStimulus(24'hFFFFFD, 1'b1, 24'hFFFFFE, 1'b1, 1'b1);
    waitDrain();

    // Backpressure: output held stable, input and coef ports closed.
    doReset();
    @(posedge axis_clk);
    #1 m_axis_tready = 1'b0;
    applyStimulus(24'h123456, 1'b0, 24'h123456, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge axis_clk);
      if (m_axis_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("hold_tvalid_seen", seen, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge axis_clk);
      checkOutput("hold_tvalid", m_axis_tvalid, 1);
      checkOutput("hold_tdata", m_axis_tdata, 24'h123456);
      checkOutput("hold_s_tready", s_axis_tready, 0);
      checkOutput("hold_coef_ready", coef_wr_ready, 0);
    end
    beatsBefore = outBeats;
    @(posedge axis_clk);
    #1 m_axis_tready = 1'b1;
    repeat (5) @(negedge axis_clk);
    checkOutput("one_beat", outBeats - beatsBefore, 1);
    checkOutput("tvalid_after_release", m_axis_tvalid, 0);
    waitDrain();

    // tlast resynchronises the channel counter; history follows channel 0.
    doReset();
    writeCoef(1, 18'h08000);
    applyStimulus(24'h000100, 1'b1, 24'h000100, 1'b1, 1'b1);
    applyStimulus(24'h000200, 1'b0, 24'h000280, 1'b0, 1'b1);
    applyStimulus(24'h000400, 1'b1, 24'h000400, 1'b1, 1'b1);
    applyStimulus(24'h000010, 1'b0, 24'h000110, 1'b0, 1'b1);
    waitDrain();

    // Reset in the middle of MAC discards the result and restores identity.
    doReset();
    writeCoef(0, 18'h08000);
    beatsBefore = outBeats;
    applyStimulus(24'h0ABCDE, 1'b0, 24'h000000, 1'b0, 1'b0);
    repeat (10) @(posedge axis_clk);
    doReset();
    checkOutput("no_beat_after_reset", outBeats - beatsBefore, 0);
    applyStimulus(24'h654321, 1'b0, 24'h654321, 1'b0, 1'b1);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
